// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises one handshake-accepted word into a start/data/parity/stop
// frame on a registered, idle-high serial line.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);
    localparam int TW = $clog2(CLKS_PER_BIT) + 1;
    localparam int IW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [TW-1:0]        timer, timer_n;
    logic [IW-1:0]        bit_idx, bit_idx_n;
    logic                 stop_cnt, stop_cnt_n;
    logic                 par, par_n, out_n;
    logic                 last;

    assign last     = timer == TW'(CLKS_PER_BIT - 1);
    assign tx_ready = state == IDLE;
    assign tx_busy  = state != IDLE;
    assign tx_done  = state == STOP && last && stop_cnt == 1'(STOP_BITS - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            timer    <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            par      <= 1'b0;
            tx_out   <= 1'b1;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            timer    <= timer_n;
            bit_idx  <= bit_idx_n;
            stop_cnt <= stop_cnt_n;
            par      <= par_n;
            tx_out   <= out_n;
        end
    end

    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_idx_n  = bit_idx;
        stop_cnt_n = stop_cnt;
        par_n      = par;
        timer_n    = (state == IDLE || last) ? '0 : timer + 1'b1;
        case (state)
            IDLE: if (tx_valid) begin
                state_n = START;
                shift_n = tx_data;
                par_n   = ^tx_data ^ 1'(PARITY_ODD);
            end
            START: if (last) state_n = DATA;
            DATA: if (last) begin
                shift_n   = shift >> 1;
                bit_idx_n = bit_idx + 1'b1;
                if (bit_idx == IW'(DATA_BITS - 1)) begin
                    bit_idx_n = '0;
                    state_n   = PARITY_EN != 0 ? PARITY : STOP;
                end
            end
            PARITY: if (last) state_n = STOP;
            STOP: if (last) begin
                stop_cnt_n = stop_cnt + 1'b1;
                if (tx_done) begin
                    stop_cnt_n = 1'b0;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // line level is derived from the next state so tx_out stays a clean flop output
        out_n = state_n == START  ? 1'b0 :
                state_n == DATA   ? shift_n[0] :
                state_n == PARITY ? par_n : 1'b1;
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: several parameterisations run in parallel, each checked cycle by
// cycle against a slot-based frame model built from the byte value.
module tb_uart_transmitter;
    localparam int NCFG = 5;

    logic clk = 1'b0;
    int   checks = 0, failures = 0, finished = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int C  = g == 3 ? 1 : g == 4 ? 3 : 4;
        localparam int DB = g == 4 ? 5 : 8;
        localparam int PE = g == 2 ? 0 : 1;
        localparam int PO = (g == 1 || g == 4) ? 1 : 0;
        localparam int SB = (g == 2 || g == 4) ? 1 : 2;
        localparam int F  = (1 + DB + PE + SB) * C;

        logic          rst = 1'b1, tx_valid = 1'b0;
        logic [DB-1:0] tx_data = '0;
        logic          tx_ready, tx_out, tx_busy, tx_done;

        uart_transmitter #(.CLKS_PER_BIT(C), .DATA_BITS(DB), .PARITY_EN(PE),
                           .PARITY_ODD(PO), .STOP_BITS(SB)) dut (
            .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
            .tx_ready(tx_ready), .tx_out(tx_out), .tx_busy(tx_busy), .tx_done(tx_done));

        // line level of frame slot s: start, data LSB first, optional parity, stop bits
        function automatic logic exp_bit(input logic [7:0] d, input int s);
            if (s == 0) return 1'b0;
            if (s <= DB) return d[s-1];
            if (PE == 1 && s == DB + 1) return 1'(($countones(d[DB-1:0]) + PO) % 2);
            return 1'b1;
        endfunction

        task automatic idle_chk(input string t);
            chk($sformatf("c%0d %s ready", g, t), tx_ready, 1);
            chk($sformatf("c%0d %s out", g, t), tx_out, 1);
            chk($sformatf("c%0d %s busy", g, t), tx_busy, 0);
            chk($sformatf("c%0d %s done", g, t), tx_done, 0);
        endtask

        // entered and left on a negedge with the line idle
        task automatic send(input logic [7:0] d, input bit noise, input bit keep);
            tx_data  = d[DB-1:0];
            tx_valid = 1'b1;
            chk($sformatf("c%0d accept ready", g), tx_ready, 1);
            @(posedge clk);
            for (int k = 0; k < F; k++) begin
                @(negedge clk);
                chk($sformatf("c%0d d%0h out k%0d", g, d, k), tx_out, exp_bit(d, k / C));
                chk($sformatf("c%0d d%0h busy k%0d", g, d, k), tx_busy, 1);
                chk($sformatf("c%0d d%0h ready k%0d", g, d, k), tx_ready, 0);
                chk($sformatf("c%0d d%0h done k%0d", g, d, k), tx_done, k == F - 1);
                if (k == F - 1) tx_valid = keep;
                else if (noise) begin
                    tx_valid = 1'($urandom);
                    tx_data  = DB'($urandom);
                end
            end
            @(negedge clk);
            idle_chk("gap");
        endtask

        task automatic abort(input logic [7:0] d);
            tx_data  = d[DB-1:0];
            tx_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            tx_valid = 1'b0;
            repeat (C + $urandom_range(0, C * DB - 1)) @(negedge clk);
            chk($sformatf("c%0d pre-rst busy", g), tx_busy, 1);
            rst = 1'b1;
            @(negedge clk);
            idle_chk("rst");
            tx_valid = 1'b1;
            @(negedge clk);
            idle_chk("rst+valid");
            rst      = 1'b0;
            tx_valid = 1'b0;
            repeat (2 * C + 2) begin
                @(negedge clk);
                idle_chk("post-rst");
            end
        endtask

        initial begin
            repeat (2) @(negedge clk);
            idle_chk("reset");
            rst = 1'b0;
            @(negedge clk);
            send(8'hA5, 1'b0, 1'b0);
            send(8'h07, 1'b0, 1'b0);
            send(8'h00, 1'b0, 1'b0);
            send(8'h55, 1'b0, 1'b1);
            send(8'hAA, 1'b0, 1'b0);
            send(8'h96, 1'b1, 1'b0);
            abort(8'hC3);
            send(8'h3C, 1'b0, 1'b0);
            for (int i = 0; i < 15; i++) begin
                bit b;
                b = 1'($urandom);
                send(8'($urandom), 1'($urandom), b);
                if (!b) repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    idle_chk("idle");
                end
            end
            finished++;
        end
    end

    initial begin
        for (int i = 0; i < 40000 && finished < NCFG; i++) @(posedge clk);
        chk("all configs finished", finished, NCFG);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
